round_ctrl: RTL and testbench
=============================

ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 The block SHALL use: clk  in  1  system clock, all logic on its rising edge.
REQ-002 The block SHALL use: reset  in  1  synchronous, active-high reset.
REQ-003 The block SHALL use: start  in  1  one-cycle pulse; begins a game from IDLE or LOST.
REQ-004 The block SHALL use: tick  in  1  one-cycle 1 Hz enable pulse for the countdown.
REQ-005 The block SHALL use: submit  in  1  one-cycle pulse; guess_val valid this cycle.
REQ-006 The block SHALL use: guess_val  in  10  player guess, unsigned binary, 0-999.
REQ-007 The block SHALL use: max_timer  in  7  round time limit in seconds, from the difficulty FSM.
REQ-008 The block SHALL use: max_guess  in  3  allowed guesses per round, from the difficulty FSM.
REQ-009 The block SHALL use: secret  in  10  new target number from the random source.
REQ-010 The block SHALL use: secret_valid  in  1  secret is valid this cycle.
REQ-011 The block SHALL use: secret_req  out  1  high while waiting for a new secret.
REQ-012 The block SHALL use: timer  out  7  seconds remaining in the current round.
REQ-013 The block SHALL use: guess  out  3  guesses used in the current round.
REQ-014 The block SHALL use: round  out  3  rounds won in the current game.
REQ-015 The block SHALL use: hint  out  2  hint code: 00 none, 01 too low, 10 too high, 11 equal.
REQ-016 The block SHALL use: fail  out  1  high while in LOST.

Function
REQ-017 States SHALL be IDLE, FETCH, PLAY, HIT and LOST.
REQ-018 IDLE: on start, the block SHALL clear round and hint and go to FETCH.
REQ-019 FETCH: secret_req SHALL be 1; when secret_valid=1 the block SHALL capture secret, load timer=max_timer, clear guess and hint, and go to PLAY.
REQ-020 max_timer and max_guess SHALL be sampled only on the FETCH->PLAY transition; changes during PLAY SHALL be ignored.
REQ-021 PLAY: when tick=1 and timer>0, timer SHALL decrement by 1.
REQ-022 PLAY: when submit=1, guess SHALL increment by 1 (saturating at 7), and hint SHALL be set to 01, 10 or 11 by comparing guess_val with the captured secret.
REQ-023 PLAY: when submit=1 and guess_val equals the secret, the next state SHALL be HIT.
REQ-024 PLAY: the next state SHALL be LOST when the timer reaches 0, or when a wrong submit makes guess+1 >= the sampled max_guess.
REQ-025 When submit and tick occur in the same cycle, the comparison SHALL take priority: a correct guess SHALL go to HIT even if the timer reaches 0 in that cycle.
REQ-026 Latency SHALL be one cycle: a submit in cycle N SHALL make guess, hint and state visible in cycle N+1.
REQ-027 HIT SHALL last one cycle, increment round (saturating at 7), hold hint=11, and then go to FETCH.
REQ-028 LOST SHALL hold timer, guess, round and hint frozen with fail=1; on start it SHALL clear round and go to FETCH.
REQ-029 start SHALL be ignored in FETCH, PLAY and HIT; submit SHALL be ignored outside PLAY; tick SHALL be ignored outside PLAY.
REQ-030 A sampled max_timer=0 SHALL cause PLAY to go to LOST on its first cycle; a sampled max_guess=0 SHALL be treated as 1.

Reset
REQ-031 reset SHALL force IDLE and set timer=0, guess=0, round=0, hint=00, fail=0, secret_req=0, and the secret register to 0 on the next clk edge, in every state including mid-round; reset SHALL take priority over all other inputs.

Structure
REQ-032 State typedef, hint codes and the width constants (NUM_W=10, TIMER_W=7, CNT_W=3) SHALL live in the shared package number_guess_pkg.
REQ-033 The countdown SHALL be a sub-module, round_timer, with load, load value, tick enable and zero flag.

Verification
REQ-034 reset, start, secret_valid with secret=500, max_timer=30, max_guess=3 -> PLAY with timer=30, guess=0; a submit of 500 -> hint=11, HIT for one cycle, round=1, secret_req=1.
REQ-035 In PLAY with secret=500, submits of 100 and then 900 -> hint=01 then 10, guess=1 then 2, state remains PLAY.
REQ-036 max_guess=3, three wrong submits -> LOST after the third, fail=1, guess=3; a fourth submit produces no change.
REQ-037 max_timer=2, two ticks with no submit -> timer 2,1,0 and then LOST; start -> FETCH with round=0.
REQ-038 timer=1, tick and a correct submit in the same cycle -> HIT, not LOST.
REQ-039 reset asserted in PLAY with timer=17, guess=2, round=2 -> next cycle IDLE with all outputs 0.

Source files
------------

// File: rtl/number_guess_pkg.sv
// Shared types and constants for the number-guessing game datapath.
// Holds the round state encoding, hint codes and small counter helpers.
package number_guess_pkg;

  localparam int NUM_W   = 10;
  localparam int TIMER_W = 7;
  localparam int CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_HIT   = 3'd3,
    ST_LOST  = 3'd4
  } state_t;

  typedef logic [1:0] hint_t;

  localparam hint_t HINT_NONE  = 2'b00;
  localparam hint_t HINT_LOW   = 2'b01;
  localparam hint_t HINT_HIGH  = 2'b10;
  localparam hint_t HINT_EQUAL = 2'b11;

  function automatic hint_t compare_guess(input logic [NUM_W-1:0] value,
                                          input logic [NUM_W-1:0] target);
    hint_t code;
    if (value < target) begin
      code = HINT_LOW;
    end else if (value > target) begin
      code = HINT_HIGH;
    end else begin
      code = HINT_EQUAL;
    end
    return code;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == {CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + CNT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round countdown: loads the round time limit and counts down on tick
// enables, stopping at zero.
module round_timer
  import number_guess_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick_en,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  // Countdown register; load wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {TIMER_W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (tick_en && (count != {TIMER_W{1'b0}})) begin
      count <= count - TIMER_W'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {TIMER_W{1'b0}});

endmodule

// File: rtl/round_ctrl.sv
// Round controller for the number-guessing game: fetches a secret, runs the
// countdown and guess budget, scores hits and reports a lost game.
module round_ctrl
  import number_guess_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic               submit,
  input  logic [NUM_W-1:0]   guess_val,
  input  logic [TIMER_W-1:0] max_timer,
  input  logic [CNT_W-1:0]   max_guess,
  input  logic [NUM_W-1:0]   secret,
  input  logic               secret_valid,
  output logic               secret_req,
  output logic [TIMER_W-1:0] timer,
  output logic [CNT_W-1:0]   guess,
  output logic [CNT_W-1:0]   round,
  output logic [1:0]         hint,
  output logic               fail
);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_W-1:0]   secret_reg;
  logic [NUM_W-1:0]   secret_nxt;
  logic [CNT_W-1:0]   guess_limit;
  logic [CNT_W-1:0]   limit_nxt;
  logic [CNT_W-1:0]   guess_nxt;
  logic [CNT_W-1:0]   round_nxt;
  hint_t              hint_nxt;
  logic               timer_load;
  logic               timer_tick;
  logic               timer_zero;
  logic [CNT_W:0]     guesses_after;

  round_timer u_round_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (max_timer),
    .tick_en  (timer_tick),
    .count    (timer),
    .zero     (timer_zero)
  );

  // Wrong-guess budget check is done one bit wider so guess+1 never wraps.
  assign guesses_after = {1'b0, guess} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state and next-datapath decode.
  always_comb begin
    state_nxt  = state;
    secret_nxt = secret_reg;
    limit_nxt  = guess_limit;
    guess_nxt  = guess;
    round_nxt  = round;
    hint_nxt   = hint;
    timer_load = 1'b0;
    timer_tick = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          round_nxt = {CNT_W{1'b0}};
          hint_nxt  = HINT_NONE;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (secret_valid) begin
          secret_nxt = secret;
          timer_load = 1'b1;
          guess_nxt  = {CNT_W{1'b0}};
          hint_nxt   = HINT_NONE;
          // A zero guess budget would lose before any guess; treat it as one.
          limit_nxt  = (max_guess == {CNT_W{1'b0}}) ? CNT_W'(1) : max_guess;
          state_nxt  = ST_PLAY;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_PLAY: begin
        timer_tick = tick;
        if (submit) begin
          guess_nxt = sat_inc(guess);
          hint_nxt  = compare_guess(guess_val, secret_reg);
          if (guess_val == secret_reg) begin
            state_nxt = ST_HIT;
          end else if ((guesses_after >= {1'b0, guess_limit}) || timer_zero) begin
            state_nxt = ST_LOST;
          end else begin
            state_nxt = ST_PLAY;
          end
        end else if (timer_zero) begin
          state_nxt = ST_LOST;
        end else begin
          state_nxt = ST_PLAY;
        end
      end
      ST_HIT: begin
        round_nxt = sat_inc(round);
        hint_nxt  = HINT_EQUAL;
        state_nxt = ST_FETCH;
      end
      ST_LOST: begin
        if (start) begin
          round_nxt = {CNT_W{1'b0}};
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_LOST;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      secret_reg  <= {NUM_W{1'b0}};
      guess_limit <= CNT_W'(1);
      guess       <= {CNT_W{1'b0}};
      round       <= {CNT_W{1'b0}};
      hint        <= HINT_NONE;
      fail        <= 1'b0;
      secret_req  <= 1'b0;
    end else begin
      state       <= state_nxt;
      secret_reg  <= secret_nxt;
      guess_limit <= limit_nxt;
      guess       <= guess_nxt;
      round       <= round_nxt;
      hint        <= hint_nxt;
      fail        <= (state_nxt == ST_LOST);
      secret_req  <= (state_nxt == ST_FETCH);
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: directed game scenarios followed by
// random play, all compared against a behavioural game model.
module tb_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, tick, submit, secret_valid;
  logic [9:0] guess_val, secret;
  logic [6:0] max_timer;
  logic [2:0] max_guess;
  logic       secret_req, fail;
  logic [6:0] timer;
  logic [2:0] guess, round;
  logic [1:0] dut_hint;

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: phase 0 idle, 1 waiting for secret, 2 playing, 3 won, 4 lost.
  int m_phase, m_timer, m_guess, m_round, m_hint, m_secret, m_limit;

  round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .tick         (tick),
    .submit       (submit),
    .guess_val    (guess_val),
    .max_timer    (max_timer),
    .max_guess    (max_guess),
    .secret       (secret),
    .secret_valid (secret_valid),
    .secret_req   (secret_req),
    .timer        (timer),
    .guess        (guess),
    .round        (round),
    .hint         (dut_hint),
    .fail         (fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_step();
    int old_timer;
    if (reset) begin
      m_phase = 0; m_timer = 0; m_guess = 0; m_round = 0; m_hint = 0; m_secret = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_round = 0; m_hint = 0; m_phase = 1; end
        1: if (secret_valid) begin
             m_secret = int'(secret);
             m_timer  = int'(max_timer);
             m_limit  = (max_guess == 3'd0) ? 1 : int'(max_guess);
             m_guess  = 0;
             m_hint   = 0;
             m_phase  = 2;
           end
        2: begin
             old_timer = m_timer;
             if (tick && m_timer > 0) m_timer = m_timer - 1;
             if (submit) begin
               int g;
               g = int'(guess_val);
               if (g < m_secret) m_hint = 1;
               else if (g > m_secret) m_hint = 2;
               else m_hint = 3;
               if (g == m_secret) m_phase = 3;
               else if (m_guess + 1 >= m_limit || old_timer == 0) m_phase = 4;
               m_guess = (m_guess < 7) ? m_guess + 1 : 7;
             end else if (old_timer == 0) begin
               m_phase = 4;
             end
           end
        3: begin
             m_round = (m_round < 7) ? m_round + 1 : 7;
             m_hint  = 3;
             m_phase = 1;
           end
        4: if (start) begin m_round = 0; m_phase = 1; end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    check("timer", int'(timer), m_timer);
    check("guess", int'(guess), m_guess);
    check("round", int'(round), m_round);
    check("hint", int'(dut_hint), m_hint);
    check("fail", int'(fail), (m_phase == 4) ? 1 : 0);
    check("secret_req", int'(secret_req), (m_phase == 1) ? 1 : 0);
  endtask

  // One clock: model consumes the same inputs the DUT sees, then outputs are compared.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    reset = 1'b0; start = 1'b0; tick = 1'b0; submit = 1'b0; secret_valid = 1'b0;
  endtask

  task automatic fetch(input int sec, input int mt, input int mg);
    secret = sec[9:0]; max_timer = mt[6:0]; max_guess = mg[2:0]; secret_valid = 1'b1;
    cycle();
  endtask

  task automatic do_submit(input int gv, input bit with_tick);
    guess_val = gv[9:0]; submit = 1'b1; tick = with_tick;
    cycle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; submit = 1'b0; secret_valid = 1'b0;
    guess_val = 10'd0; secret = 10'd0; max_timer = 7'd0; max_guess = 3'd0;
    m_phase = 0; m_timer = 0; m_guess = 0; m_round = 0; m_hint = 0; m_secret = 0; m_limit = 1;
    cycle();
    check("reset_timer", int'(timer), 0);

    // Correct first guess wins the round.
    start = 1'b1; cycle();
    check("fetch_req", int'(secret_req), 1);
    fetch(500, 30, 3);
    check("play_timer", int'(timer), 30);
    check("play_guess", int'(guess), 0);
    do_submit(500, 1'b0);
    check("hit_hint", int'(dut_hint), 3);
    cycle();
    check("won_round", int'(round), 1);
    check("won_req", int'(secret_req), 1);

    // Low then high guesses; limit change during play must be ignored.
    fetch(500, 30, 3);
    max_guess = 3'd1; max_timer = 7'd1;
    do_submit(100, 1'b0);
    check("low_hint", int'(dut_hint), 1);
    do_submit(900, 1'b0);
    check("high_hint", int'(dut_hint), 2);
    check("high_guess", int'(guess), 2);
    check("still_play", int'(fail), 0);
    do_submit(200, 1'b0);
    check("lost_fail", int'(fail), 1);
    check("lost_guess", int'(guess), 3);
    do_submit(500, 1'b1);
    check("frozen_guess", int'(guess), 3);
    check("frozen_hint", int'(dut_hint), 1);

    // Timeout after two ticks, then restart clears the round count.
    start = 1'b1; cycle();
    check("restart_round", int'(round), 0);
    fetch(321, 2, 5);
    tick = 1'b1; cycle();
    tick = 1'b1; cycle();
    check("timer_zero", int'(timer), 0);
    check("zero_not_lost", int'(fail), 0);
    cycle();
    check("timeout_fail", int'(fail), 1);
    start = 1'b1; cycle();

    // Tick and correct guess together with one second left.
    fetch(77, 1, 2);
    do_submit(77, 1'b1);
    check("race_hint", int'(dut_hint), 3);
    check("race_fail", int'(fail), 0);
    cycle();

    // Zero time limit and zero guess budget.
    fetch(10, 0, 4);
    cycle();
    check("zero_time_lost", int'(fail), 1);
    start = 1'b1; cycle();
    fetch(10, 9, 0);
    do_submit(11, 1'b0);
    check("zero_budget_lost", int'(fail), 1);

    // Reset in the middle of a round.
    start = 1'b1; cycle();
    fetch(500, 17, 5); do_submit(500, 1'b0); cycle();
    fetch(500, 17, 5); do_submit(500, 1'b0); cycle();
    fetch(500, 17, 5);
    do_submit(1, 1'b0);
    do_submit(2, 1'b0);
    check("mid_timer", int'(timer), 17);
    check("mid_round", int'(round), 2);
    reset = 1'b1; start = 1'b1; submit = 1'b1; guess_val = 10'd500; tick = 1'b1;
    cycle();
    check("rst_guess", int'(guess), 0);
    check("rst_round", int'(round), 0);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      start        = ($urandom_range(0, 9) == 0);
      tick         = ($urandom_range(0, 3) == 0);
      submit       = ($urandom_range(0, 4) == 0);
      secret_valid = ($urandom_range(0, 2) == 0);
      secret       = 10'($urandom_range(0, 999));
      max_timer    = 7'($urandom_range(0, 12));
      max_guess    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) guess_val = m_secret[9:0];
      else guess_val = 10'($urandom_range(0, 999));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
